// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: channel data, select/mode/enable and registered result of mux_scan_ctrl.
// Optional feature macro: MUX_SCAN_MASK_EN (adds the per-channel ch_mask signal).
// WIDTH and CHANNELS must match the parameters of the attached mux_scan_ctrl.
interface mux_scan_ctrl_if #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SELW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] x;
    logic [SELW-1:0]           sel;
    logic                      mode;
    logic                      en;
`ifdef MUX_SCAN_MASK_EN
    logic [CHANNELS-1:0]       ch_mask;
`endif
    logic [WIDTH-1:0]          Q;
    logic [SELW-1:0]           cur_sel;
    logic                      valid;
    logic                      sel_err;
    logic                      wrap;

`ifdef MUX_SCAN_MASK_EN
    modport master (
        output x, sel, mode, en, ch_mask,
        input  Q, cur_sel, valid, sel_err, wrap
    );
    modport slave (
        input  x, sel, mode, en, ch_mask,
        output Q, cur_sel, valid, sel_err, wrap
    );
`else
    modport master (
        output x, sel, mode, en,
        input  Q, cur_sel, valid, sel_err, wrap
    );
    modport slave (
        input  x, sel, mode, en,
        output Q, cur_sel, valid, sel_err, wrap
    );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: registered N-channel multiplexer with manual select and dwell-based auto-scan.
// Optional feature macro: MUX_SCAN_MASK_EN (scan skips / manual select rejects masked channels).
module mux_scan_ctrl #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 2
) (
    input logic            clk,
    input logic            rst,
    mux_scan_ctrl_if.slave bus
);
    localparam int unsigned SELW       = $clog2(CHANNELS);
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [SELW-1:0]  cur_q, cur_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    logic [CHANNELS-1:0] avail;
    logic [SELW-1:0]     first_ch, above_ch, nxt_ch;
    logic                above_found, sel_ok, cur_ok, any_ch, nxt_wrap;

    // Selects one channel out of the packed bus; indices beyond CHANNELS-1 yield zero.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] xv,
                                              input logic [SELW-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (SELW'(i) == idx) r = xv[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

`ifdef MUX_SCAN_MASK_EN
    assign avail = bus.ch_mask;
`else
    assign avail = '1;
`endif

    // Channel search: lowest usable channel, next usable above cur_sel, select legality.
    always_comb begin
        first_ch    = '0;
        above_ch    = '0;
        above_found = 1'b0;
        sel_ok      = 1'b0;
        cur_ok      = 1'b0;
        // Descending so the lowest matching index is the one left standing.
        for (int j = int'(CHANNELS) - 1; j >= 0; j--) begin
            if (avail[j]) begin
                first_ch = SELW'(j);
                if (SELW'(j) > cur_q) begin
                    above_found = 1'b1;
                    above_ch    = SELW'(j);
                end
                if (SELW'(j) == bus.sel) sel_ok = 1'b1;
                if (SELW'(j) == cur_q)   cur_ok = 1'b1;
            end
        end
    end

    assign any_ch   = |avail;
    // No usable channel above the current one means the advance crosses CHANNELS-1.
    assign nxt_ch   = above_found ? above_ch : first_ch;
    assign nxt_wrap = ~above_found;

    // Next-state and registered-output decode; en dominates mode.
    always_comb begin
        state_d = !bus.en ? StIdle : (bus.mode ? StScan : StManual);
        q_d     = q_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            StManual: begin
                if (sel_ok) begin
                    q_d     = pick(bus.x, bus.sel);
                    cur_d   = bus.sel;
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            StScan: begin
                if (!any_ch) begin
                    err_d = 1'b1;
                end else if (state_q != StScan) begin
                    // Every entry into scan restarts at the first usable channel.
                    cur_d   = first_ch;
                    cnt_d   = '0;
                    q_d     = pick(bus.x, first_ch);
                    valid_d = 1'b1;
                end else if (cnt_q == DWELL_LAST || !cur_ok) begin
                    cur_d   = nxt_ch;
                    cnt_d   = '0;
                    wrap_d  = nxt_wrap;
                    q_d     = pick(bus.x, nxt_ch);
                    valid_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    q_d     = pick(bus.x, cur_q);
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.cur_sel = cur_q;
    assign bus.valid   = valid_q;
    assign bus.sel_err = err_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench for mux_scan_ctrl with an expected-result queue.
// Three instances: A (W1,C4,D2), B (W4,C3,D2), C (W1,C4,D1).
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_scan_ctrl_if #(.WIDTH(1), .CHANNELS(4)) ia ();
    mux_scan_ctrl_if #(.WIDTH(4), .CHANNELS(3)) ib ();
    mux_scan_ctrl_if #(.WIDTH(1), .CHANNELS(4)) ic ();

    mux_scan_ctrl #(.WIDTH(1), .CHANNELS(4), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mux_scan_ctrl #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    mux_scan_ctrl #(.WIDTH(1), .CHANNELS(4), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    typedef struct {
        int         id;
        string      tag;
        logic [3:0] q;
        logic [1:0] cur;
        logic       v;
        logic       e;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input string tag, input logic [3:0] q,
                        input logic [1:0] cur, input logic v, input logic e, input logic w);
        exp_t t;
        t.id = id; t.tag = tag; t.q = q; t.cur = cur; t.v = v; t.e = e; t.w = w;
        sb.push_back(t);
    endtask

    task automatic check_outs(input string tag, input int id, input logic [3:0] q,
                              input logic [1:0] cur, input logic v, input logic e, input logic w);
        logic [3:0] oq;
        logic [1:0] oc;
        logic       ov, oe, ow;
        case (id)
            0: begin oq = {3'b0, ia.Q}; oc = ia.cur_sel; ov = ia.valid; oe = ia.sel_err; ow = ia.wrap; end
            1: begin oq = ib.Q; oc = ib.cur_sel; ov = ib.valid; oe = ib.sel_err; ow = ib.wrap; end
            default: begin
                oq = {3'b0, ic.Q}; oc = ic.cur_sel; ov = ic.valid; oe = ic.sel_err; ow = ic.wrap;
            end
        endcase
        check({tag, ".q"},       oq,          q);
        check({tag, ".cur_sel"}, {2'b0, oc},  {2'b0, cur});
        check({tag, ".valid"},   {3'b0, ov},  {3'b0, v});
        check({tag, ".sel_err"}, {3'b0, oe},  {3'b0, e});
        check({tag, ".wrap"},    {3'b0, ow},  {3'b0, w});
    endtask

    // Advance one clock, then compare every queued expectation against its instance.
    task automatic tick();
        exp_t t;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            check_outs(t.tag, t.id, t.q, t.cur, t.v, t.e, t.w);
        end
    endtask

    logic       man_q [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] scan_c [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                                2'd0, 2'd0, 2'd1, 2'd1};
    logic       scan_q [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] d1_c [6]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       d1_q [6]    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MUX_SCAN_MASK_EN
    logic [1:0] mk_c [5]    = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    logic       mk_q [5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    initial begin
        rst = 1'b1;
        ia.x = '0; ia.sel = '0; ia.mode = 1'b0; ia.en = 1'b0;
        ib.x = '0; ib.sel = '0; ib.mode = 1'b0; ib.en = 1'b0;
        ic.x = '0; ic.sel = '0; ic.mode = 1'b0; ic.en = 1'b0;
`ifdef MUX_SCAN_MASK_EN
        ia.ch_mask = '1; ib.ch_mask = '1; ic.ch_mask = '1;
`endif
        #2;
        check_outs("reset_a", 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_outs("reset_b", 1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Manual select walk on A.
        ia.x = 4'b0101; ia.en = 1'b1; ia.mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            ia.sel = 2'(s);
            push(0, "man_walk", {3'b0, man_q[s]}, 2'(s), 1'b1, 1'b0, 1'b0);
            tick();
        end

        // Out-of-range manual select on the 3-channel B.
        ib.x = {4'hC, 4'hB, 4'hA}; ib.en = 1'b1; ib.mode = 1'b0;
        ib.sel = 2'd1; push(1, "b_sel1", 4'hB, 2'd1, 1'b1, 1'b0, 1'b0); tick();
        ib.sel = 2'd3; push(1, "b_oor",  4'hB, 2'd1, 1'b0, 1'b1, 1'b0); tick();
        ib.sel = 2'd2; push(1, "b_sel2", 4'hC, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        ib.sel = 2'd0; push(1, "b_sel0", 4'hA, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        ib.en = 1'b0;  push(1, "b_idle", 4'hA, 2'd0, 1'b0, 1'b0, 1'b0); tick();

        // Scan on A with DWELL=2, wrap on the 3->0 step.
        ia.mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(0, "scan", {3'b0, scan_q[i]}, scan_c[i], 1'b1, 1'b0, i == 8);
            tick();
        end
        ia.x = 4'b1010;
        push(0, "scan_live", 4'h0, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();

        // Partial-cycle reset while scanning channel 2.
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        push(0, "post_rst0", 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        push(1, "post_rst_b", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        push(0, "post_rst1", 4'h0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        push(0, "post_rst2", 4'h1, 2'd1, 1'b1, 1'b0, 1'b0); tick();

        // Enable dropped mid-scan, then restored.
        ia.en = 1'b0;
        push(0, "idle0", 4'h1, 2'd1, 1'b0, 1'b0, 1'b0); tick();
        push(0, "idle1", 4'h1, 2'd1, 1'b0, 1'b0, 1'b0); tick();
        ia.en = 1'b1;
        push(0, "reen0", 4'h0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        push(0, "reen1", 4'h0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        push(0, "reen2", 4'h1, 2'd1, 1'b1, 1'b0, 1'b0); tick();

        // Manual interlude, then scan restarts at channel 0.
        ia.mode = 1'b0; ia.sel = 2'd3;
        push(0, "mid_man", 4'h1, 2'd3, 1'b1, 1'b0, 1'b0); tick();
        ia.mode = 1'b1;
        push(0, "rescan", 4'h0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        ia.en = 1'b0;

        // DWELL=1 on C advances every cycle.
        ic.x = 4'b0110; ic.en = 1'b1; ic.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(2, "dwell1", {3'b0, d1_q[i]}, d1_c[i], 1'b1, 1'b0, i == 4);
            tick();
        end

`ifdef MUX_SCAN_MASK_EN
        ic.en = 1'b0;
        push(2, "mk_idle", 4'h1, 2'd1, 1'b0, 1'b0, 1'b0); tick();
        ic.ch_mask = 4'b1010; ic.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(2, "mk_scan", {3'b0, mk_q[i]}, mk_c[i], 1'b1, 1'b0, i == 2 || i == 4);
            tick();
        end
        ic.ch_mask = 4'b0000;
        push(2, "mk_zero", 4'h1, 2'd1, 1'b0, 1'b1, 1'b0); tick();
        ic.ch_mask = 4'b1010; ic.mode = 1'b0; ic.sel = 2'd0;
        push(2, "mk_man_bad", 4'h1, 2'd1, 1'b0, 1'b1, 1'b0); tick();
        ic.sel = 2'd3;
        push(2, "mk_man_ok", 4'h0, 2'd3, 1'b1, 1'b0, 1'b0); tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
